// File: rtl/alu_mdu_ctrl.sv
// ALU control decoder plus iterative multiply/divide sequencer with HI/LO.
// alucontrol, mfhilo, hilo_rdata and stall are purely combinational; only the
// MDU path (state, counter, accumulator, HI/LO) is registered.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation in flight; mult/div may issue, mthi/mtlo may write
// RUN   | one shift-add / shift-subtract iteration per cycle, WIDTH total
// FIX   | sign correction of product/quotient/remainder, HI/LO written
//
// WIDTH must be even and at least 4.
module alu_mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [3:0]       alucontrol,
  output logic             mfhilo,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             mdu_busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic is_rtype, is_mul, is_div, is_signed_op;
  logic is_mthi, is_mtlo, is_mfhi, is_mflo, is_mdu_op, issue;

  logic [WIDTH-1:0]   abs_a, abs_b, mul_addend, div_rem, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

  // Instruction-class decode; MDU ops only exist under R-type aluop.
  always_comb begin
    is_rtype     = (aluop == 2'b10);
    is_mul       = is_rtype & ((funct == 6'b011000) | (funct == 6'b011001));
    is_div       = is_rtype & ((funct == 6'b011010) | (funct == 6'b011011));
    is_signed_op = ~funct[0];
    is_mthi      = is_rtype & (funct == 6'b010001);
    is_mtlo      = is_rtype & (funct == 6'b010011);
    is_mfhi      = is_rtype & (funct == 6'b010000);
    is_mflo      = is_rtype & (funct == 6'b010010);
    is_mdu_op    = is_mul | is_div | is_mthi | is_mtlo | is_mfhi | is_mflo;
  end

  // Single-cycle ALU control word, independent of MDU state.
  always_comb begin
    alucontrol = 4'b0000;
    case (aluop)
      2'b00, 2'b11: alucontrol = 4'b0010;
      2'b01:        alucontrol = 4'b0110;
      default: begin
        case (funct)
          6'b100000, 6'b100001: alucontrol = 4'b0010;
          6'b100010, 6'b100011: alucontrol = 4'b0110;
          6'b100100:            alucontrol = 4'b0000;
          6'b100101:            alucontrol = 4'b0001;
          6'b100110:            alucontrol = 4'b0011;
          6'b100111:            alucontrol = 4'b0100;
          6'b101010:            alucontrol = 4'b0111;
          6'b101011:            alucontrol = 4'b1111;
          default:              alucontrol = 4'b0000;
        endcase
      end
    endcase
  end

  // Hazard handling and HI/LO read port.
  always_comb begin
    mdu_busy   = (state_q != S_IDLE);
    stall      = ~reset & en & mdu_busy & is_mdu_op;
    issue      = en & ~stall & (state_q == S_IDLE) & (is_mul | is_div);
    mfhilo     = is_mfhi | is_mflo;
    hilo_rdata = is_mfhi ? hi_q : lo_q;
    hi         = hi_q;
    lo         = lo_q;
  end

  // Iteration datapath: operand magnitudes, one shift-add / restoring
  // shift-subtract step, and the final sign correction.
  always_comb begin
    abs_a = (is_signed_op & srca[WIDTH-1]) ? -srca : srca;
    abs_b = (is_signed_op & srcb[WIDTH-1]) ? -srcb : srcb;

    // acc holds {partial product, remaining multiplier bits}.
    mul_addend = acc_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    // acc holds {partial remainder, dividend bits shifting into quotient}.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // MDU sequencer next-state, including mthi/mtlo writes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    // Moves are stalled while busy, so they never collide with a FIX write.
    if (en & ~stall & is_mthi) hi_d = srca;
    if (en & ~stall & is_mtlo) lo_d = srca;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d    = S_RUN;
          cnt_d      = CNT_LOAD;
          acc_d      = {{WIDTH{1'b0}}, abs_a};
          opb_d      = abs_b;
          is_div_d   = is_div;
          neg_res_d  = is_signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          neg_rem_d  = is_signed_op & is_div & srca[WIDTH-1];
          div_zero_d = is_div & (srcb == '0);
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (is_div_q) begin
          // Remainder of x/0 is |x| re-signed, i.e. the dividend itself.
          hi_d = rem_fix;
          lo_d = div_zero_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and HI/LO registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl: decode table, MDU result table, and
// hand-written hazard / reset / move sequences.
module tb_alu_mdu_ctrl;
  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         reset, en;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] srca, srcb;
  logic [3:0]   alucontrol;
  logic         mfhilo, mdu_busy, stall;
  logic [W-1:0] hilo_rdata, hi, lo;

  int vectors = 0;
  int miscompares = 0;

  alu_mdu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .aluop(aluop), .funct(funct),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .mfhilo(mfhilo),
    .hilo_rdata(hilo_rdata), .mdu_busy(mdu_busy), .stall(stall),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] ctl;
    logic       mfhilo;
  } dec_vec_t;

  typedef struct {
    string        name;
    logic [5:0]   funct;
    logic [W-1:0] a, b, hi, lo;
  } mdu_vec_t;

  dec_vec_t dec_tab[13];
  mdu_vec_t mdu_tab[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_mdu(input mdu_vec_t v);
    int n;
    @(posedge clk); #1;
    aluop = 2'b10; funct = v.funct; srca = v.a; srcb = v.b; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    n = 0;
    while (mdu_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({v.name, " busy cycles"}, n, W + 1);
    check({v.name, " hi"}, hi, v.hi);
    check({v.name, " lo"}, lo, v.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    dec_tab[0]  = '{2'b10, 6'b100111, 4'b0100, 1'b0};
    dec_tab[1]  = '{2'b10, 6'b101011, 4'b1111, 1'b0};
    dec_tab[2]  = '{2'b10, 6'b111111, 4'b0000, 1'b0};
    dec_tab[3]  = '{2'b00, 6'b100111, 4'b0010, 1'b0};
    dec_tab[4]  = '{2'b01, 6'b000000, 4'b0110, 1'b0};
    dec_tab[5]  = '{2'b11, 6'b100010, 4'b0010, 1'b0};
    dec_tab[6]  = '{2'b10, 6'b100001, 4'b0010, 1'b0};
    dec_tab[7]  = '{2'b10, 6'b100011, 4'b0110, 1'b0};
    dec_tab[8]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    dec_tab[9]  = '{2'b10, 6'b100110, 4'b0011, 1'b0};
    dec_tab[10] = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    dec_tab[11] = '{2'b10, 6'b010000, 4'b0000, 1'b1};
    dec_tab[12] = '{2'b00, 6'b010010, 4'b0010, 1'b0};

    mdu_tab[0] = '{"multu max",  F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    mdu_tab[1] = '{"mult -3x7",  F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    mdu_tab[2] = '{"mult min^2", F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    mdu_tab[3] = '{"div -7/2",   F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    mdu_tab[4] = '{"divu 5/0",   F_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    mdu_tab[5] = '{"div ovf",    F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    mdu_tab[6] = '{"div 7/-2",   F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    mdu_tab[7] = '{"div -8/0",   F_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    mdu_tab[8] = '{"divu max/10", F_DIVU, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
    mdu_tab[9] = '{"multu x16",  F_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    reset = 1'b1; en = 1'b0; aluop = 2'b00; funct = 6'd0; srca = '0; srcb = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", mdu_busy, 0);
    check("reset stall", stall, 0);

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      aluop = dec_tab[i].aluop; funct = dec_tab[i].funct; en = 1'b1;
      @(negedge clk);
      check($sformatf("dec%0d alucontrol", i), alucontrol, dec_tab[i].ctl);
      check($sformatf("dec%0d mfhilo", i), mfhilo, dec_tab[i].mfhilo);
      check($sformatf("dec%0d stall", i), stall, 0);
    end
    @(posedge clk); #1 en = 1'b0;

    for (int i = 0; i < 10; i++) run_mdu(mdu_tab[i]);

    // Dependent mflo presented right after mult issue, held until it completes.
    @(posedge clk); #1;
    aluop = 2'b10; funct = F_MULT; srca = 32'd6; srcb = 32'd7; en = 1'b1;
    @(posedge clk); #1;
    funct = F_MFLO; srca = '0; srcb = '0;
    @(negedge clk);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("hazard stall cycles", n, W + 1);
    check("hazard mflo data", hilo_rdata, 42);
    check("hazard mfhilo", mfhilo, 1);
    @(posedge clk); #1 en = 1'b0;

    // Non-MDU instruction while busy must not stall; then mflo gets new LO.
    @(posedge clk); #1;
    funct = F_MULT; srca = 32'd2; srcb = 32'd3; en = 1'b1;
    @(posedge clk); #1;
    funct = F_ADD;
    @(negedge clk);
    check("add while busy: busy", mdu_busy, 1);
    check("add while busy: stall", stall, 0);
    check("add while busy: alucontrol", alucontrol, 4'b0010);
    @(posedge clk); #1;
    funct = F_DIVU;
    @(negedge clk);
    check("second mdu op stalled", stall, 1);
    @(posedge clk); #1;
    funct = F_MFLO;
    @(negedge clk);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mflo after add wait", n, W - 1);
    check("mflo after add data", hilo_rdata, 6);
    @(posedge clk); #1 en = 1'b0;

    // Reset in the middle of a long multiply.
    @(posedge clk); #1;
    funct = F_MULTU; srca = 32'hFFFFFFFF; srcb = 32'hFFFFFFFF; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1; en = 1'b1; funct = F_MFLO;
    @(negedge clk);
    check("stall low in reset", stall, 0);
    check("busy before reset edge", mdu_busy, 1);
    @(negedge clk);
    check("abort busy", mdu_busy, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b0; funct = F_MTHI; srca = 32'h00001234;
    @(negedge clk);
    check("mthi busy", mdu_busy, 0);
    check("mthi stall", stall, 0);
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    check("mthi hi", hi, 32'h00001234);
    check("mthi lo", lo, 0);
    check("mthi busy after", mdu_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
